ct_cp0_lpmd_mc: RTL and testbench



---
 rtl/ct_cp0_lpmd_pkg.sv | 38 +++
 rtl/ct_cp0_lpmd_mc_if.sv | 28 ++
 rtl/ct_cp0_lpmd_cnt.sv | 46 ++++
 rtl/ct_cp0_lpmd_mc.sv | 160 ++++++++++++++++
 tb/tb_ct_cp0_lpmd_mc.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/ct_cp0_lpmd_pkg.sv
// ---------------------------------------------------------------------------
// ct_cp0_lpmd_pkg
// Shared definitions for the CP0 low-power-mode controller:
//   - FSM state encoding (IDLE/REQ/LPMD/WAKE)
//   - lpmd instruction mode codes
//   - lpmd_b codes driven to BIU/HAD
//   - encode_lpmd_b(): maps an instruction mode onto its lpmd_b code
// ---------------------------------------------------------------------------
package ct_cp0_lpmd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_LPMD = 2'b10,
      ST_WAKE = 2'b11
   } lpmd_state_e;

   localparam logic [1:0] MODE_WAIT = 2'b00;
   localparam logic [1:0] MODE_DOZE = 2'b01;
   localparam logic [1:0] MODE_STOP = 2'b10;

   localparam logic [1:0] LPMD_B_NORMAL = 2'b11;
   localparam logic [1:0] LPMD_B_WAIT   = 2'b10;
   localparam logic [1:0] LPMD_B_DOZE   = 2'b01;
   localparam logic [1:0] LPMD_B_STOP   = 2'b00;

   // The reserved mode 11 falls into the default arm and behaves as WAIT.
   function automatic logic [1:0] encode_lpmd_b(input logic [1:0] mode);
      logic [1:0] code;
      case (mode)
         MODE_DOZE: code = LPMD_B_DOZE;
         MODE_STOP: code = LPMD_B_STOP;
         default:   code = LPMD_B_WAIT;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/ct_cp0_lpmd_mc_if.sv
// ---------------------------------------------------------------------------
// ct_cp0_lpmd_mc_if
// Per-unit no-op handshake bundle between the CP0 lpmd controller and the
// NUM_UNIT maskable execution units.
//   unit_en            : 1 = unit takes part in the handshake
//   unit_no_op         : per-unit idle acknowledge
//   cp0_unit_no_op_req : per-unit no-op request from CP0
// master = CP0 controller side, slave = unit/environment side.
// ---------------------------------------------------------------------------
interface ct_cp0_lpmd_mc_if #(
   parameter int NUM_UNIT = 4
);
   logic [NUM_UNIT-1:0] unit_en;
   logic [NUM_UNIT-1:0] unit_no_op;
   logic [NUM_UNIT-1:0] cp0_unit_no_op_req;

   modport master (
      input  unit_en,
      input  unit_no_op,
      output cp0_unit_no_op_req
   );

   modport slave (
      output unit_en,
      output unit_no_op,
      input  cp0_unit_no_op_req
   );
endinterface

// File: rtl/ct_cp0_lpmd_cnt.sv
// ---------------------------------------------------------------------------
// ct_cp0_lpmd_cnt
// Saturating TMO_W-bit up-counter with synchronous clear, count enable and a
// terminal-compare output. One instance is shared by the ack-timeout (REQ)
// and wake-settle (WAKE) phases; the parent selects the compare value.
//   clk, rst : clock and synchronous active-high reset
//   clr      : force the count to zero (wins over en)
//   en       : count up by one, holding at all-ones
//   term_val : value compared against the current count
//   term_hit : current count equals term_val
// ---------------------------------------------------------------------------
module ct_cp0_lpmd_cnt #(
   parameter int TMO_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [TMO_W-1:0] term_val,
   output logic             term_hit
);

   logic [TMO_W-1:0] cnt_q;
   logic [TMO_W-1:0] cnt_d;

   // Saturation keeps a long REQ phase from wrapping back to zero.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != {TMO_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign term_hit = (cnt_q == term_val);

endmodule

// File: rtl/ct_cp0_lpmd_mc.sv
// ---------------------------------------------------------------------------
// ct_cp0_lpmd_mc
// CP0 low-power-mode controller. Takes an lpmd (WFI-class) instruction,
// requests no-op from all enabled units, enters the selected low-power mode
// once every enabled unit acks, waits for a wake source, holds a wake-settle
// delay and then completes the instruction.
// Ports:
//   forever_cpuclk, cpurst       : ungated clock, sync active-high reset
//   inst_lpmd_ex1_ex2, _mode     : lpmd instruction and its mode
//   rtu_yy_xx_flush              : pipeline flush (honoured only in REQ)
//   rtu_yy_xx_dbgon              : debug mode; restores the clock, aborts REQ
//   had_cp0_xx_dbg               : debug wake source
//   regs_lpmd_int_vld            : interrupt wake source / early exit
//   unit_if                      : per-unit no-op handshake (master side)
//   cp0_biu_lpmd_b/cp0_had_lpmd_b: registered lpmd_b code
//   cp0_yy_clk_en                : core clock enable (&lpmd_b)
//   lpmd_cmplt, lpmd_ack_tmo     : one-cycle complete / timeout-abort pulses
//   lpmd_top_cur_state           : FSM state
// ---------------------------------------------------------------------------
module ct_cp0_lpmd_mc
   import ct_cp0_lpmd_pkg::*;
#(
   parameter int NUM_UNIT = 4,
   parameter int TMO_W    = 8,
   parameter int WAKE_DLY = 4
) (
   input  logic                   forever_cpuclk,
   input  logic                   cpurst,
   input  logic                   inst_lpmd_ex1_ex2,
   input  logic [1:0]             inst_lpmd_mode,
   input  logic                   rtu_yy_xx_flush,
   input  logic                   rtu_yy_xx_dbgon,
   input  logic                   had_cp0_xx_dbg,
   input  logic                   regs_lpmd_int_vld,
   ct_cp0_lpmd_mc_if.master       unit_if,
   output logic [1:0]             cp0_biu_lpmd_b,
   output logic [1:0]             cp0_had_lpmd_b,
   output logic                   cp0_yy_clk_en,
   output logic                   lpmd_cmplt,
   output logic                   lpmd_ack_tmo,
   output logic [1:0]             lpmd_top_cur_state
);

   localparam logic [TMO_W-1:0] TMO_TERM  = {TMO_W{1'b1}};
   localparam logic [TMO_W-1:0] WAKE_TERM = TMO_W'(WAKE_DLY - 1);

   lpmd_state_e         state_q, state_d;
   logic [1:0]          mode_q, mode_d;
   logic [1:0]          lpmd_b_q, lpmd_b_d;
   logic [NUM_UNIT-1:0] unit_en;
   logic [NUM_UNIT-1:0] unit_no_op;
   logic [NUM_UNIT-1:0] no_op_req;
   logic                all_ack;
   logic                req_abort;
   logic                wake_src;
   logic                cnt_clr;
   logic                cnt_en;
   logic                cnt_hit;
   logic [TMO_W-1:0]    cnt_term;
   logic                cmplt;
   logic                tmo;

   assign unit_en    = unit_if.unit_en;
   assign unit_no_op = unit_if.unit_no_op;

   // Masked-off units count as already idle.
   assign all_ack   = &(unit_no_op | ~unit_en);
   assign req_abort = rtu_yy_xx_flush | rtu_yy_xx_dbgon;
   assign wake_src  = regs_lpmd_int_vld | had_cp0_xx_dbg | rtu_yy_xx_dbgon;

   // Counter is held at zero outside REQ/WAKE so each phase starts from 0
   // on its first cycle; the compare value follows the active phase.
   assign cnt_clr  = (state_q == ST_IDLE) || (state_q == ST_LPMD);
   assign cnt_en   = (state_q == ST_REQ)  || (state_q == ST_WAKE);
   assign cnt_term = (state_q == ST_WAKE) ? WAKE_TERM : TMO_TERM;

   ct_cp0_lpmd_cnt #(
      .TMO_W    (TMO_W)
   ) u_cnt (
      .clk      (forever_cpuclk),
      .rst      (cpurst),
      .clr      (cnt_clr),
      .en       (cnt_en),
      .term_val (cnt_term),
      .term_hit (cnt_hit)
   );

   // Next-state, lpmd_b and pulse outputs. REQ priority: abort, pending
   // interrupt (early exit), ack, timeout. Debug mode always restores the
   // normal lpmd_b code regardless of state.
   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      lpmd_b_d  = lpmd_b_q;
      no_op_req = '0;
      cmplt     = 1'b0;
      tmo       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (inst_lpmd_ex1_ex2 && !rtu_yy_xx_flush) begin
               state_d = ST_REQ;
               mode_d  = inst_lpmd_mode;
            end
         end
         ST_REQ: begin
            no_op_req = unit_en;
            if (req_abort) begin
               state_d = ST_IDLE;
            end else if (regs_lpmd_int_vld) begin
               state_d = ST_IDLE;
               cmplt   = 1'b1;
            end else if (all_ack) begin
               state_d  = ST_LPMD;
               lpmd_b_d = encode_lpmd_b(mode_q);
            end else if (cnt_hit) begin
               state_d = ST_IDLE;
               cmplt   = 1'b1;
               tmo     = 1'b1;
            end
         end
         ST_LPMD: begin
            if (wake_src) begin
               state_d  = ST_WAKE;
               lpmd_b_d = LPMD_B_NORMAL;
            end
         end
         ST_WAKE: begin
            if (cnt_hit) begin
               state_d = ST_IDLE;
               cmplt   = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (rtu_yy_xx_dbgon) begin
         lpmd_b_d = LPMD_B_NORMAL;
      end
   end

   always_ff @(posedge forever_cpuclk) begin
      if (cpurst) begin
         state_q  <= ST_IDLE;
         mode_q   <= MODE_WAIT;
         lpmd_b_q <= LPMD_B_NORMAL;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         lpmd_b_q <= lpmd_b_d;
      end
   end

   assign unit_if.cp0_unit_no_op_req = no_op_req;
   assign cp0_biu_lpmd_b     = lpmd_b_q;
   assign cp0_had_lpmd_b     = lpmd_b_q;
   assign cp0_yy_clk_en      = &lpmd_b_q;
   assign lpmd_cmplt         = cmplt;
   assign lpmd_ack_tmo       = tmo;
   assign lpmd_top_cur_state = state_q;

endmodule

// File: tb/tb_ct_cp0_lpmd_mc.sv
// ---------------------------------------------------------------------------
// tb_ct_cp0_lpmd_mc
// Directed self-checking bench for ct_cp0_lpmd_mc (NUM_UNIT=4, TMO_W=4,
// WAKE_DLY=3). Each step drives the inputs right after a falling edge,
// pushes the expected outputs for that cycle onto a scoreboard queue, and
// pops/compares them 1 time unit later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_ct_cp0_lpmd_mc;

   typedef struct {
      logic [1:0] st;
      logic [3:0] req;
      logic [1:0] lb;
      logic       clk_en;
      logic       cmplt;
      logic       tmo;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       inst;
   logic [1:0] mode;
   logic       flush;
   logic       dbgon;
   logic       dbg;
   logic       int_vld;
   logic [1:0] biu_lpmd_b;
   logic [1:0] had_lpmd_b;
   logic       clk_en;
   logic       cmplt;
   logic       ack_tmo;
   logic [1:0] cur_state;

   int   checks;
   int   failures;
   exp_t sb_q[$];

   ct_cp0_lpmd_mc_if #(.NUM_UNIT(4)) uif ();

   ct_cp0_lpmd_mc #(
      .NUM_UNIT (4),
      .TMO_W    (4),
      .WAKE_DLY (3)
   ) dut (
      .forever_cpuclk     (clk),
      .cpurst             (rst),
      .inst_lpmd_ex1_ex2  (inst),
      .inst_lpmd_mode     (mode),
      .rtu_yy_xx_flush    (flush),
      .rtu_yy_xx_dbgon    (dbgon),
      .had_cp0_xx_dbg     (dbg),
      .regs_lpmd_int_vld  (int_vld),
      .unit_if            (uif.master),
      .cp0_biu_lpmd_b     (biu_lpmd_b),
      .cp0_had_lpmd_b     (had_lpmd_b),
      .cp0_yy_clk_en      (clk_en),
      .lpmd_cmplt         (cmplt),
      .lpmd_ack_tmo       (ack_tmo),
      .lpmd_top_cur_state (cur_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic apply_stimulus(input logic i_inst, input logic [1:0] i_mode,
                                 input logic i_flush, input logic i_dbgon,
                                 input logic i_dbg, input logic i_int,
                                 input logic [3:0] i_en, input logic [3:0] i_noop);
      inst           = i_inst;
      mode           = i_mode;
      flush          = i_flush;
      dbgon          = i_dbgon;
      dbg            = i_dbg;
      int_vld        = i_int;
      uif.unit_en    = i_en;
      uif.unit_no_op = i_noop;
   endtask

   task automatic check_field(input string tag, input string name,
                              input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("[TB] FAIL %s.%s observed=%0h expected=%0h", tag, name, obs, exp);
      end
   endtask

   task automatic check_output(input string tag);
      exp_t e;
      e = sb_q.pop_front();
      check_field(tag, "state",  {6'd0, cur_state},              {6'd0, e.st});
      check_field(tag, "req",    {4'd0, uif.cp0_unit_no_op_req}, {4'd0, e.req});
      check_field(tag, "biu_b",  {6'd0, biu_lpmd_b},             {6'd0, e.lb});
      check_field(tag, "had_b",  {6'd0, had_lpmd_b},             {6'd0, e.lb});
      check_field(tag, "clk_en", {7'd0, clk_en},                 {7'd0, e.clk_en});
      check_field(tag, "cmplt",  {7'd0, cmplt},                  {7'd0, e.cmplt});
      check_field(tag, "tmo",    {7'd0, ack_tmo},                {7'd0, e.tmo});
   endtask

   // Push the expected outputs for the current cycle, compare them, then
   // advance to the next falling edge where new stimulus may be applied.
   task automatic expect_cycle(input logic [1:0] st, input logic [3:0] req,
                               input logic [1:0] lb, input logic c,
                               input logic t, input string tag);
      exp_t e;
      e.st     = st;
      e.req    = req;
      e.lb     = lb;
      e.clk_en = (lb == 2'b11);
      e.cmplt  = c;
      e.tmo    = t;
      sb_q.push_back(e);
      #1;
      check_output(tag);
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      apply_stimulus(0, 2'b00, 0, 0, 0, 0, 4'hF, 4'h0);
      @(negedge clk);
      expect_cycle(2'b00, 4'h0, 2'b11, 0, 0, "reset");
      rst = 1'b0;

      $display("[TB] DOZE entry with all units, interrupt wake");
      apply_stimulus(1, 2'b01, 0, 0, 0, 0, 4'hF, 4'h0);
      expect_cycle(2'b00, 4'h0, 2'b11, 0, 0, "s1_idle");
      apply_stimulus(0, 2'b10, 0, 0, 0, 0, 4'hF, 4'h0);
      expect_cycle(2'b01, 4'hF, 2'b11, 0, 0, "s1_req0");
      expect_cycle(2'b01, 4'hF, 2'b11, 0, 0, "s1_req1");
      expect_cycle(2'b01, 4'hF, 2'b11, 0, 0, "s1_req2");
      apply_stimulus(0, 2'b10, 0, 0, 0, 0, 4'hF, 4'hF);
      expect_cycle(2'b01, 4'hF, 2'b11, 0, 0, "s1_ack");
      apply_stimulus(0, 2'b10, 0, 0, 0, 0, 4'hF, 4'h0);
      expect_cycle(2'b10, 4'h0, 2'b01, 0, 0, "s1_lpmd");
      apply_stimulus(0, 2'b10, 1, 0, 0, 0, 4'hF, 4'h0);
      expect_cycle(2'b10, 4'h0, 2'b01, 0, 0, "s1_lpmd_flush");
      apply_stimulus(0, 2'b10, 0, 0, 0, 1, 4'hF, 4'h0);
      expect_cycle(2'b10, 4'h0, 2'b01, 0, 0, "s1_wake_src");
      apply_stimulus(0, 2'b10, 0, 0, 0, 0, 4'hF, 4'h0);
      expect_cycle(2'b11, 4'h0, 2'b11, 0, 0, "s1_wake0");
      expect_cycle(2'b11, 4'h0, 2'b11, 0, 0, "s1_wake1");
      expect_cycle(2'b11, 4'h0, 2'b11, 1, 0, "s1_cmplt");
      expect_cycle(2'b00, 4'h0, 2'b11, 0, 0, "s1_done");

      $display("[TB] Masked units 1/3, debug-mode wake");
      apply_stimulus(1, 2'b00, 0, 0, 0, 0, 4'h5, 4'h5);
      expect_cycle(2'b00, 4'h0, 2'b11, 0, 0, "s2_idle");
      apply_stimulus(0, 2'b00, 0, 0, 0, 0, 4'h5, 4'h5);
      expect_cycle(2'b01, 4'h5, 2'b11, 0, 0, "s2_req_ack");
      apply_stimulus(0, 2'b00, 0, 1, 0, 0, 4'h5, 4'h5);
      expect_cycle(2'b10, 4'h0, 2'b10, 0, 0, "s2_lpmd_wait");
      apply_stimulus(0, 2'b00, 0, 0, 0, 0, 4'h5, 4'h5);
      expect_cycle(2'b11, 4'h0, 2'b11, 0, 0, "s2_wake0");
      expect_cycle(2'b11, 4'h0, 2'b11, 0, 0, "s2_wake1");
      expect_cycle(2'b11, 4'h0, 2'b11, 1, 0, "s2_cmplt");
      expect_cycle(2'b00, 4'h0, 2'b11, 0, 0, "s2_done");

      $display("[TB] Unit 0 not acking, flush in REQ");
      apply_stimulus(1, 2'b00, 0, 0, 0, 0, 4'h5, 4'h4);
      expect_cycle(2'b00, 4'h0, 2'b11, 0, 0, "s3_idle");
      apply_stimulus(0, 2'b00, 0, 0, 0, 0, 4'h5, 4'h4);
      expect_cycle(2'b01, 4'h5, 2'b11, 0, 0, "s3_req0");
      expect_cycle(2'b01, 4'h5, 2'b11, 0, 0, "s3_req1");
      apply_stimulus(0, 2'b00, 1, 0, 0, 0, 4'h5, 4'h4);
      expect_cycle(2'b01, 4'h5, 2'b11, 0, 0, "s3_flush");
      apply_stimulus(0, 2'b00, 0, 0, 0, 0, 4'h5, 4'h4);
      expect_cycle(2'b00, 4'h0, 2'b11, 0, 0, "s3_aborted");

      $display("[TB] Ack timeout");
      apply_stimulus(1, 2'b01, 0, 0, 0, 0, 4'hF, 4'h0);
      expect_cycle(2'b00, 4'h0, 2'b11, 0, 0, "s4_idle");
      apply_stimulus(0, 2'b01, 0, 0, 0, 0, 4'hF, 4'h0);
      for (int i = 1; i <= 15; i++) begin
         expect_cycle(2'b01, 4'hF, 2'b11, 0, 0, $sformatf("s4_wait%0d", i));
      end
      expect_cycle(2'b01, 4'hF, 2'b11, 1, 1, "s4_tmo");
      expect_cycle(2'b00, 4'h0, 2'b11, 0, 0, "s4_done");

      $display("[TB] Interrupt pending at issue, beats simultaneous ack");
      apply_stimulus(1, 2'b01, 0, 0, 0, 1, 4'hF, 4'hF);
      expect_cycle(2'b00, 4'h0, 2'b11, 0, 0, "s5_idle");
      apply_stimulus(0, 2'b01, 0, 0, 0, 1, 4'hF, 4'hF);
      expect_cycle(2'b01, 4'hF, 2'b11, 1, 0, "s5_early");
      apply_stimulus(0, 2'b01, 0, 0, 0, 0, 4'hF, 4'h0);
      expect_cycle(2'b00, 4'h0, 2'b11, 0, 0, "s5_done");

      $display("[TB] Reset during STOP");
      apply_stimulus(1, 2'b10, 0, 0, 0, 0, 4'hF, 4'hF);
      expect_cycle(2'b00, 4'h0, 2'b11, 0, 0, "s6_idle");
      apply_stimulus(0, 2'b10, 0, 0, 0, 0, 4'hF, 4'hF);
      expect_cycle(2'b01, 4'hF, 2'b11, 0, 0, "s6_req_ack");
      rst = 1'b1;
      expect_cycle(2'b10, 4'h0, 2'b00, 0, 0, "s6_stop");
      rst = 1'b0;
      apply_stimulus(0, 2'b00, 0, 0, 0, 0, 4'hF, 4'h0);
      expect_cycle(2'b00, 4'h0, 2'b11, 0, 0, "s6_after_rst");

      $display("[TB] Reserved mode, debug wake together with ack");
      apply_stimulus(1, 2'b11, 0, 0, 0, 0, 4'hF, 4'h0);
      expect_cycle(2'b00, 4'h0, 2'b11, 0, 0, "s7_idle");
      apply_stimulus(0, 2'b11, 0, 0, 1, 0, 4'hF, 4'hF);
      expect_cycle(2'b01, 4'hF, 2'b11, 0, 0, "s7_ack_dbg");
      apply_stimulus(0, 2'b11, 0, 0, 1, 0, 4'hF, 4'h0);
      expect_cycle(2'b10, 4'h0, 2'b10, 0, 0, "s7_lpmd_wait");
      apply_stimulus(0, 2'b11, 0, 0, 0, 0, 4'hF, 4'h0);
      expect_cycle(2'b11, 4'h0, 2'b11, 0, 0, "s7_wake0");
      expect_cycle(2'b11, 4'h0, 2'b11, 0, 0, "s7_wake1");
      expect_cycle(2'b11, 4'h0, 2'b11, 1, 0, "s7_cmplt");
      expect_cycle(2'b00, 4'h0, 2'b11, 0, 0, "s7_done");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
